// File: rtl/contador_display_bcd.sv
// rtl/contador_display_bcd.sv - binary-to-BCD (double-dabble) converter driving active-low 7-segment digits

module contador_display_bcd #(
    parameter int N      = 6,
    parameter int DIGITS = 2
) (
    input  logic                  clk,
    input  logic                  reset_sw,
    input  logic [N-1:0]          valor,
    output logic [4*DIGITS-1:0]   bcd,
    output logic [7*DIGITS-1:0]   segmentos,
    output logic                  ocupado,
    output logic                  listo
);

    localparam int AW = 4 * DIGITS;
    localparam int CW = $clog2(N + 1);
    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [6:0] SEG_CERO  = 7'b1000000;

    // Parameter sanity: the input width must be supported and every input value must fit the digit count
    if (N < 1 || N > 13) begin : g_n_fuera_de_rango
        $fatal(1, "contador_display_bcd: N must be in 1..13");
    end
    if ((2 ** N) - 1 >= 10 ** DIGITS) begin : g_digitos_insuficientes
        $fatal(1, "contador_display_bcd: DIGITS too small for N");
    end

    typedef enum logic [1:0] {REPOSO, CARGA, DESPLAZA, FIN} estado_t;

    estado_t         estado;
    logic [N-1:0]    ultimo;
    logic [N-1:0]    desp;
    logic [AW-1:0]   acc;
    logic [CW-1:0]   cnt;
    logic [AW-1:0]   acc_aj;
    logic [7*DIGITS-1:0] seg_cod;
    logic            visto;

    function automatic logic [6:0] seg7(input logic [3:0] d);
        case (d)
            4'd0:    seg7 = 7'b1000000;
            4'd1:    seg7 = 7'b1111001;
            4'd2:    seg7 = 7'b0100100;
            4'd3:    seg7 = 7'b0110000;
            4'd4:    seg7 = 7'b0011001;
            4'd5:    seg7 = 7'b0010010;
            4'd6:    seg7 = 7'b0000010;
            4'd7:    seg7 = 7'b1111000;
            4'd8:    seg7 = 7'b0000000;
            4'd9:    seg7 = 7'b0010000;
            default: seg7 = SEG_BLANK;
        endcase
    endfunction

    // Add-3 correction applied to every nibble before each shift
    always_comb begin
        acc_aj = acc;
        for (int k = 0; k < DIGITS; k++) begin
            if (acc[4*k +: 4] >= 4'd5) begin
                acc_aj[4*k +: 4] = acc[4*k +: 4] + 4'd3;
            end
        end
    end

    // Segment encoding with leading-zero blanking, scanning from the most significant digit down
    always_comb begin
        seg_cod = '0;
        visto   = 1'b0;
        for (int k = DIGITS - 1; k >= 0; k--) begin
            if (acc[4*k +: 4] != 4'd0 || k == 0) begin
                visto = 1'b1;
            end
            seg_cod[7*k +: 7] = visto ? seg7(acc[4*k +: 4]) : SEG_BLANK;
        end
    end

    // Conversion FSM; display registers are only written in FIN so partial results never show
    always_ff @(posedge clk or posedge reset_sw) begin
        if (reset_sw) begin
            estado  <= REPOSO;
            ultimo  <= '0;
            desp    <= '0;
            acc     <= '0;
            cnt     <= '0;
            bcd     <= '0;
            ocupado <= 1'b0;
            listo   <= 1'b0;
            for (int k = 0; k < DIGITS; k++) begin
                segmentos[7*k +: 7] <= (k == 0) ? SEG_CERO : SEG_BLANK;
            end
        end else begin
            listo <= 1'b0;
            case (estado)
                REPOSO: begin
                    if (valor != ultimo) begin
                        ultimo  <= valor;
                        desp    <= valor;
                        acc     <= '0;
                        ocupado <= 1'b1;
                        estado  <= CARGA;
                    end
                end
                CARGA: begin
                    cnt    <= CW'(N);
                    estado <= DESPLAZA;
                end
                DESPLAZA: begin
                    {acc, desp} <= {acc_aj[AW-2:0], desp, 1'b0};
                    cnt         <= cnt - 1'b1;
                    if (cnt == CW'(1)) begin
                        ocupado <= 1'b0;
                        estado  <= FIN;
                    end
                end
                FIN: begin
                    bcd       <= acc;
                    segmentos <= seg_cod;
                    listo     <= 1'b1;
                    estado    <= REPOSO;
                end
                default: estado <= REPOSO;
            endcase
        end
    end

endmodule

// File: tb/tb_contador_display_bcd.sv
// tb/tb_contador_display_bcd.sv - directed table-driven bench for contador_display_bcd

module tb_contador_display_bcd;

    logic        clk = 1'b0;
    logic        reset_sw;
    logic [5:0]  valor_a;
    logic [7:0]  bcd_a;
    logic [13:0] seg_a;
    logic        ocupado_a, listo_a;
    logic [9:0]  valor_b;
    logic [15:0] bcd_b;
    logic [27:0] seg_b;
    logic        ocupado_b, listo_b;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    contador_display_bcd #(.N(6), .DIGITS(2)) dut_a (
        .clk(clk), .reset_sw(reset_sw), .valor(valor_a),
        .bcd(bcd_a), .segmentos(seg_a), .ocupado(ocupado_a), .listo(listo_a)
    );

    contador_display_bcd #(.N(10), .DIGITS(4)) dut_b (
        .clk(clk), .reset_sw(reset_sw), .valor(valor_b),
        .bcd(bcd_b), .segmentos(seg_b), .ocupado(ocupado_b), .listo(listo_b)
    );

    typedef struct {
        logic [5:0]  valor;
        logic [7:0]  bcd;
        logic [13:0] seg;
    } vec_t;

    vec_t tabla [7];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Waits for listo on instance a (sel=0) or b (sel=1); ok=0 on timeout
    task automatic wait_listo(input int sel, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if ((sel == 0 && listo_a) || (sel == 1 && listo_b)) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    function automatic logic [6:0] tb_seg(input int d);
        case (d)
            0: tb_seg = 7'b1000000;
            1: tb_seg = 7'b1111001;
            2: tb_seg = 7'b0100100;
            3: tb_seg = 7'b0110000;
            4: tb_seg = 7'b0011001;
            5: tb_seg = 7'b0010010;
            6: tb_seg = 7'b0000010;
            7: tb_seg = 7'b1111000;
            8: tb_seg = 7'b0000000;
            default: tb_seg = 7'b0010000;
        endcase
    endfunction

    function automatic logic [27:0] seg_esp(input int v);
        int p;
        seg_esp = '0;
        p = 1;
        for (int k = 0; k < 4; k++) begin
            seg_esp[7*k +: 7] = (k > 0 && v < p) ? 7'b1111111 : tb_seg((v / p) % 10);
            p = p * 10;
        end
    endfunction

    function automatic logic [15:0] bcd_esp(input int v);
        bcd_esp = {4'(v / 1000), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
    endfunction

    initial begin
        bit ok;
        int occ, pulsos, t_listo, lit;
        logic [7:0] primero;
        bit visto6;

        tabla[0] = '{6'd1,  8'h01, {7'b1111111, 7'b1111001}};
        tabla[1] = '{6'd63, 8'h63, {7'b0000010, 7'b0110000}};
        tabla[2] = '{6'd10, 8'h10, {7'b1111001, 7'b1000000}};
        tabla[3] = '{6'd0,  8'h00, {7'b1111111, 7'b1000000}};
        tabla[4] = '{6'd47, 8'h47, {7'b0011001, 7'b1111000}};
        tabla[5] = '{6'd28, 8'h28, {7'b0100100, 7'b0000000}};
        tabla[6] = '{6'd59, 8'h59, {7'b0010010, 7'b0010000}};

        reset_sw = 1'b1;
        valor_a  = '0;
        valor_b  = '0;
        tick();
        tick();
        reset_sw = 1'b0;

        // Idle after reset with valor=0: nothing may happen
        occ = 0;
        pulsos = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (ocupado_a || ocupado_b) occ++;
            if (listo_a || listo_b) pulsos++;
        end
        check("reset_bcd_a", 32'(bcd_a), 32'h00);
        check("reset_seg_a", 32'(seg_a), 32'({7'b1111111, 7'b1000000}));
        check("reset_bcd_b", 32'(bcd_b), 32'h0000);
        check("reset_seg_b", 32'(seg_b), 32'({7'b1111111, 7'b1111111, 7'b1111111, 7'b1000000}));
        check("reset_ocupado_cycles", 32'(occ), 32'd0);
        check("reset_listo_pulses", 32'(pulsos), 32'd0);

        // 0 -> 1 step: latency and busy window
        valor_a = 6'd1;
        occ = 0;
        pulsos = 0;
        t_listo = -1;
        for (int i = 1; i <= 20; i++) begin
            tick();
            if (ocupado_a) occ++;
            if (listo_a) begin
                pulsos++;
                if (t_listo < 0) t_listo = i;
            end
        end
        check("step_ocupado_cycles", 32'(occ), 32'd7);
        check("step_listo_pulses", 32'(pulsos), 32'd1);
        check("step_listo_edge", 32'(t_listo), 32'd9);
        check("step_bcd", 32'(bcd_a), 32'h01);
        check("step_seg", 32'(seg_a), 32'({7'b1111111, 7'b1111001}));

        // Table of directed values (first entry equals current value and gets skipped)
        for (int i = 1; i < 7; i++) begin
            valor_a = tabla[i].valor;
            wait_listo(0, ok);
            check($sformatf("tab%0d_listo_seen", i), 32'(ok), 32'd1);
            check($sformatf("tab%0d_bcd", i), 32'(bcd_a), 32'(tabla[i].bcd));
            check($sformatf("tab%0d_seg", i), 32'(seg_a), 32'(tabla[i].seg));
        end

        // 5 -> 6 -> 7 on consecutive edges: 5 is captured, 6 is lost, 7 follows
        valor_a = 6'd5;
        tick();
        valor_a = 6'd6;
        tick();
        valor_a = 6'd7;
        pulsos = 0;
        primero = 8'hFF;
        visto6 = 1'b0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (bcd_a == 8'h06) visto6 = 1'b1;
            if (listo_a) begin
                pulsos++;
                if (pulsos == 1) primero = bcd_a;
            end
        end
        check("burst_listo_pulses", 32'(pulsos), 32'd2);
        check("burst_first_bcd", 32'(primero), 32'h05);
        check("burst_final_bcd", 32'(bcd_a), 32'h07);
        check("burst_no_six", 32'(visto6), 32'd0);

        // Asynchronous reset in the middle of converting 42
        valor_a = 6'd42;
        pulsos = 0;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (listo_a) pulsos++;
        end
        reset_sw = 1'b1;
        #1;
        check("abort_bcd", 32'(bcd_a), 32'h00);
        check("abort_seg", 32'(seg_a), 32'({7'b1111111, 7'b1000000}));
        check("abort_ocupado", 32'(ocupado_a), 32'd0);
        check("abort_listo", 32'(listo_a), 32'd0);
        tick();
        if (listo_a) pulsos++;
        reset_sw = 1'b0;
        check("abort_no_listo", 32'(pulsos), 32'd0);
        for (int i = 0; i < 30; i++) begin
            tick();
            if (listo_a) pulsos++;
        end
        check("abort_rerun_pulses", 32'(pulsos), 32'd1);
        check("abort_rerun_bcd", 32'(bcd_a), 32'h42);

        // Full sweep on the 10-bit / 4-digit instance
        check("sweep0_bcd", 32'(bcd_b), 32'(bcd_esp(0)));
        check("sweep0_seg", 32'(seg_b), 32'(seg_esp(0)));
        for (int v = 1; v < 1024; v++) begin
            valor_b = 10'(v);
            wait_listo(1, ok);
            if (!ok) begin
                check($sformatf("sweep%0d_timeout", v), 32'(ok), 32'd1);
                break;
            end
            if (bcd_b !== bcd_esp(v)) check($sformatf("sweep%0d_bcd", v), 32'(bcd_b), 32'(bcd_esp(v)));
            else n_cmp++;
            if (seg_b !== seg_esp(v)) check($sformatf("sweep%0d_seg", v), 32'(seg_b), 32'(seg_esp(v)));
            else n_cmp++;
            if (v == 7 || v == 1023) begin
                lit = 0;
                for (int k = 0; k < 4; k++) begin
                    if (seg_b[7*k +: 7] != 7'b1111111) lit++;
                end
                check($sformatf("lit_digits_%0d", v), 32'(lit), (v == 7) ? 32'd1 : 32'd4);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
